// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready stream interface.
// WIDTH-bit operands are split into STAGES slices. Each pipeline stage resolves one
// slice with GROUP-wide generate/propagate lookahead and registers the slice carry.
// Unresolved upper operand bits travel skewed alongside the completed lower sum bits.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand beat handshake (in_ready = ~out_valid | out_ready)
//   x, y, c_in, sub      operands, carry/borrow-in, 0 = add / 1 = subtract
//   out_valid/out_ready  result beat handshake
//   sum, c_out, ovf, zero  result and flags (c_out = 1 means no borrow when subtracting)
module pipelined_cla_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4,
  parameter int unsigned GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SLICE = WIDTH / STAGES;
  localparam int unsigned NGRP  = SLICE / GROUP;

  // One slice of two-level lookahead: group G/P feed the group carries, bit carries
  // inside a group come from the group carry-in. Returns {carry_out, sum}.
  function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic             ci);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic [NGRP:0]    cg;
    logic             gg;
    logic             pg;
    g     = a & b;
    p     = a ^ b;
    cg    = '0;
    cg[0] = ci;
    for (int j = 0; j < int'(NGRP); j++) begin
      gg = 1'b0;
      pg = 1'b1;
      for (int i = 0; i < int'(GROUP); i++) begin
        gg = g[j*int'(GROUP)+i] | (p[j*int'(GROUP)+i] & gg);
        pg = pg & p[j*int'(GROUP)+i];
      end
      cg[j+1] = gg | (pg & cg[j]);
    end
    c    = '0;
    c[0] = ci;
    for (int k = 0; k < int'(SLICE); k++) begin
      if (((k + 1) % int'(GROUP)) == 0) c[k+1] = cg[(k+1)/int'(GROUP)];
      else                              c[k+1] = g[k] | (p[k] & c[k]);
    end
    return {c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  // Whole pipe moves in lockstep; a stalled output freezes every stage.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam int unsigned AVAIL = WIDTH - k * SLICE;   // operand bits still unresolved
    localparam int unsigned DONE  = (k + 1) * SLICE;     // sum bits resolved after this stage

    logic [AVAIL-1:0] opa;
    logic [AVAIL-1:0] opb;
    logic             ci;
    logic             vin;
    logic [SLICE:0]   r;
    logic [DONE-1:0]  s_d;
    logic             v_q;
    logic             cy_q;
    logic [DONE-1:0]  s_q;

    if (k == 0) begin : g_src
      // Subtract folds into add: invert y and the carry-in at capture.
      assign opa = x;
      assign opb = sub ? ~y : y;
      assign ci  = sub ^ c_in;
      assign vin = in_valid;
      assign s_d = r[SLICE-1:0];
    end else begin : g_chain
      assign opa = g_stage[k-1].g_ops.a_q;
      assign opb = g_stage[k-1].g_ops.b_q;
      assign ci  = g_stage[k-1].cy_q;
      assign vin = g_stage[k-1].v_q;
      assign s_d = {r[SLICE-1:0], g_stage[k-1].s_q};
    end

    assign r = cla_slice(opa[SLICE-1:0], opb[SLICE-1:0], ci);

    // Data only loads with a valid beat so bubbles never disturb the result registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q  <= 1'b0;
        cy_q <= 1'b0;
        s_q  <= '0;
      end else if (adv) begin
        v_q <= vin;
        if (vin) begin
          cy_q <= r[SLICE];
          s_q  <= s_d;
        end
      end
    end

    if (AVAIL > SLICE) begin : g_ops
      // Upper operand slices skewed forward for later stages.
      logic [AVAIL-SLICE-1:0] a_q;
      logic [AVAIL-SLICE-1:0] b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && vin) begin
          a_q <= opa[AVAIL-1:SLICE];
          b_q <= opb[AVAIL-1:SLICE];
        end
      end
    end else begin : g_flags
      // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
      logic c_msb;
      logic ovf_q;
      logic zero_q;
      assign c_msb = opa[SLICE-1] ^ opb[SLICE-1] ^ r[SLICE-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv && vin) begin
          ovf_q  <= c_msb ^ r[SLICE];
          zero_q <= ~|s_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign c_out     = g_stage[STAGES-1].cy_q;
  assign ovf       = g_stage[STAGES-1].g_flags.ovf_q;
  assign zero      = g_stage[STAGES-1].g_flags.zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder: 16-bit/4-stage and 32-bit/1-stage instances.
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] x, y, sum;
  logic        c_in, sub, c_out, ovf, zero;

  logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w;
  logic [31:0] x_w, y_w, sum_w;
  logic        c_in_w, sub_w, c_out_w, ovf_w, zero_w;

  int passed = 0;
  int total  = 0;

  pipelined_cla_adder #(.WIDTH(16), .STAGES(4), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .c_out(c_out), .ovf(ovf), .zero(zero));

  pipelined_cla_adder #(.WIDTH(32), .STAGES(1), .GROUP(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w), .x(x_w), .y(y_w),
    .c_in(c_in_w), .sub(sub_w), .out_valid(out_valid_w), .out_ready(out_ready_w), .sum(sum_w),
    .c_out(c_out_w), .ovf(ovf_w), .zero(zero_w));

  typedef struct {
    logic [15:0] a, b;
    logic        ci, sb;
    logic [15:0] s;
    logic        co, ov, z;
  } vec_t;

  vec_t tbl [8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic vld);
    x = v.a; y = v.b; c_in = v.ci; sub = v.sb; in_valid = vld;
  endtask

  task automatic init_tbl;
    //        a        b        ci    sb    sum      co    ov    z
    tbl[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'hABCD, 16'h5433, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; x = 16'hA5A5; y = 16'h5A5A; c_in = 1'b1; sub = 1'b0;
    in_valid_w = 1'b0; out_ready_w = 1'b1; x_w = 32'hDEAD_BEEF; y_w = 32'h1234_5678;
    c_in_w = 1'b0; sub_w = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
    total++;
    if ({out_valid, sum, c_out, ovf, zero} !== 20'h0)
      $display("FAIL reset16_out: got %h want 00000", {out_valid, sum, c_out, ovf, zero});
    else passed++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset16_in_ready: got %b want 1", in_ready);
    else passed++;
    total++;
    if ({out_valid_w, sum_w, c_out_w, ovf_w, zero_w} !== 36'h0)
      $display("FAIL reset32_out: got %h want 0", {out_valid_w, sum_w, c_out_w, ovf_w, zero_w});
    else passed++;
    total++;
    if (in_ready_w !== 1'b1) $display("FAIL reset32_in_ready: got %b want 1", in_ready_w);
    else passed++;
    // Idle cycles with garbage operands must leave the result registers at 0.
    tick; tick; tick; tick; tick;
    total++;
    if ({out_valid, sum, c_out, ovf, zero} !== 20'h0)
      $display("FAIL idle16_out: got %h want 00000", {out_valid, sum, c_out, ovf, zero});
    else passed++;
  endtask

  task automatic test_wrap_add;
    x = 16'hFFFF; y = 16'h0001; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick;
    total++;
    if (out_valid !== 1'b0) $display("FAIL wrap_early: got out_valid %b want 0", out_valid);
    else passed++;
    tick;
    total++;
    if ({out_valid, sum, c_out, ovf, zero} !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b1})
      $display("FAIL wrap_add: got %h want %h", {out_valid, sum, c_out, ovf, zero},
               {1'b1, 16'h0000, 1'b1, 1'b0, 1'b1});
    else passed++;
    tick;
    total++;
    if (out_valid !== 1'b0) $display("FAIL wrap_drain: got out_valid %b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_overflow;
    x = 16'h7FFF; y = 16'h0001; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick; tick;
    total++;
    if ({out_valid, sum, c_out, ovf, zero} !== {1'b1, 16'h8000, 1'b0, 1'b1, 1'b0})
      $display("FAIL ovf_pos: got %h want %h", {out_valid, sum, c_out, ovf, zero},
               {1'b1, 16'h8000, 1'b0, 1'b1, 1'b0});
    else passed++;
    // -32768 - 1 overflows negatively; no borrow so c_out = 1.
    x = 16'h8000; y = 16'h0001; c_in = 1'b0; sub = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick; tick;
    total++;
    if ({out_valid, sum, c_out, ovf, zero} !== {1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0})
      $display("FAIL ovf_neg: got %h want %h", {out_valid, sum, c_out, ovf, zero},
               {1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0});
    else passed++;
    tick;
  endtask

  task automatic test_subtract;
    x = 16'h0005; y = 16'h0007; c_in = 1'b0; sub = 1'b1; in_valid = 1'b1;
    tick;
    c_in = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick;
    total++;
    if ({out_valid, sum, c_out, ovf, zero} !== {1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0})
      $display("FAIL sub_borrow: got %h want %h", {out_valid, sum, c_out, ovf, zero},
               {1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0});
    else passed++;
    tick;
    total++;
    if ({out_valid, sum, c_out, ovf, zero} !== {1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0})
      $display("FAIL sub_borrow_cin: got %h want %h", {out_valid, sum, c_out, ovf, zero},
               {1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0});
    else passed++;
    tick;
  endtask

  task automatic test_streaming;
    int   rx;
    logic exp_v;
    rx = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c < 8) drive(tbl[c], 1'b1);
      else in_valid = 1'b0;
      tick;
      exp_v = (c >= 3) && (c < 11);
      total++;
      if (out_valid !== exp_v) $display("FAIL stream_valid c=%0d: got %b want %b", c, out_valid, exp_v);
      else passed++;
      if (out_valid === 1'b1 && rx < 8) begin
        total++;
        if ({sum, c_out, ovf, zero} !== {tbl[rx].s, tbl[rx].co, tbl[rx].ov, tbl[rx].z})
          $display("FAIL stream_data[%0d]: got %h want %h", rx, {sum, c_out, ovf, zero},
                   {tbl[rx].s, tbl[rx].co, tbl[rx].ov, tbl[rx].z});
        else passed++;
        rx++;
      end
    end
  endtask

  task automatic test_back_to_back;
    int tx, rx;
    tx = 0; rx = 0;
    for (int c = 0; c < 20 && rx < 6; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      if (tx < 6) drive(tbl[tx], 1'b1);
      else in_valid = 1'b0;
      #1;
      if (c >= 4 && c <= 6) begin
        total++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready c=%0d: got %b want 0", c, in_ready);
        else passed++;
        total++;
        if ({out_valid, sum, c_out, ovf, zero} !== {1'b1, tbl[0].s, tbl[0].co, tbl[0].ov, tbl[0].z})
          $display("FAIL bp_hold c=%0d: got %h want %h", c, {out_valid, sum, c_out, ovf, zero},
                   {1'b1, tbl[0].s, tbl[0].co, tbl[0].ov, tbl[0].z});
        else passed++;
      end
      if (c >= 7) begin
        total++;
        if (out_valid !== 1'b1) $display("FAIL bp_stream c=%0d: got out_valid %b want 1", c, out_valid);
        else passed++;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        total++;
        if ({sum, c_out, ovf, zero} !== {tbl[rx].s, tbl[rx].co, tbl[rx].ov, tbl[rx].z})
          $display("FAIL bp_data[%0d]: got %h want %h", rx, {sum, c_out, ovf, zero},
                   {tbl[rx].s, tbl[rx].co, tbl[rx].ov, tbl[rx].z});
        else passed++;
        rx++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) tx++;
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (rx !== 6) $display("FAIL bp_count: got %0d results want 6", rx);
    else passed++;
    tick;
    total++;
    if (out_valid !== 1'b0) $display("FAIL bp_dup: got out_valid %b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_reset_midstream;
    int stale;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(tbl[c], 1'b1);
      tick;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++;
    if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 16'h0000})
      $display("FAIL rst_mid: got %h want %h", {out_valid, in_ready, sum}, {1'b0, 1'b1, 16'h0000});
    else passed++;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (out_valid !== 1'b0) stale++;
    end
    total++;
    if (stale !== 0) $display("FAIL rst_stale: got %0d valid cycles want 0", stale);
    else passed++;
    x = 16'h0001; y = 16'h0002; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick; tick;
    total++;
    if ({out_valid, sum, c_out, ovf, zero} !== {1'b1, 16'h0003, 1'b0, 1'b0, 1'b0})
      $display("FAIL rst_recover: got %h want %h", {out_valid, sum, c_out, ovf, zero},
               {1'b1, 16'h0003, 1'b0, 1'b0, 1'b0});
    else passed++;
    tick;
  endtask

  task automatic test_width32;
    x_w = 32'hFFFF_FFFF; y_w = 32'h0000_0001; c_in_w = 1'b0; sub_w = 1'b0; in_valid_w = 1'b1;
    tick;
    total++;
    if ({out_valid_w, sum_w, c_out_w, ovf_w, zero_w} !== {1'b1, 32'h0, 1'b1, 1'b0, 1'b1})
      $display("FAIL w32_wrap: got %h want %h", {out_valid_w, sum_w, c_out_w, ovf_w, zero_w},
               {1'b1, 32'h0, 1'b1, 1'b0, 1'b1});
    else passed++;
    x_w = 32'h0000_0000; y_w = 32'h0000_0001; sub_w = 1'b1;
    tick;
    total++;
    if ({out_valid_w, sum_w, c_out_w, ovf_w, zero_w} !== {1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0})
      $display("FAIL w32_sub: got %h want %h", {out_valid_w, sum_w, c_out_w, ovf_w, zero_w},
               {1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    else passed++;
    x_w = 32'h1234_5678; y_w = 32'h1111_1111; sub_w = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    in_valid_w = 1'b0;
    total++;
    if ({out_valid_w, in_ready_w} !== 2'b01)
      $display("FAIL w32_rst: got %b want 01", {out_valid_w, in_ready_w});
    else passed++;
    tick;
    total++;
    if (out_valid_w !== 1'b0) $display("FAIL w32_stale: got out_valid %b want 0", out_valid_w);
    else passed++;
  endtask

  initial begin
    init_tbl();
    test_reset();
    test_wrap_add();
    test_overflow();
    test_subtract();
    test_streaming();
    test_back_to_back();
    test_reset_midstream();
    test_width32();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface.
- Generalises the 16-bit combinational lookahead adder:
  - WIDTH-bit operands split into STAGES equal slices.
  - One slice is resolved per pipeline stage, with the inter-slice carry registered.
  - Adds subtract mode, signed-overflow and zero flags, and backpressure.
- Serves as the arithmetic unit feeding ALU and accumulator datapaths that need timing closure at widths above 16.

Parameters:
- WIDTH, 16: operand/result width in bits. Must be a multiple of STAGES.
- STAGES, 4: pipeline depth. Slice width SLICE = WIDTH/STAGES. STAGES=1 gives a single registered stage.
- GROUP, 4: lookahead group width inside a slice. SLICE must be a multiple of GROUP.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- c_in  in  1  carry-in (add) or borrow-in (subtract).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of MSB; in subtract mode, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset, synchronous:
  - All stage valid bits clear.
  - out_valid=0; sum, c_out, ovf, zero = 0.
  - in_ready=1 in the cycle after rst deasserts.
- Operation:
  - Add: result = x + y + c_in.
  - Subtract: result = x + ~y + ~c_in, which is x - y - c_in.
  - The inversion is applied at capture into stage 0.
- Pipeline structure:
  - Stage k (0..STAGES-1) computes bits [k*SLICE +: SLICE] using GROUP-wide generate/propagate and a lookahead carry unit, with carry-in from stage k-1's registered carry (stage 0 uses the effective carry-in).
  - Upper operand slices travel skewed alongside. Completed lower sum slices are carried forward.
  - Arithmetic is modulo 2^WIDTH.
- Flag computation, final stage only:
  - c_out = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = NOR of all WIDTH sum bits.
- Handshake:
  - Global advance: adv = ~out_valid | out_ready. in_ready = adv, combinational from out_valid/out_ready only, never from in_valid.
  - A beat is accepted when in_valid & in_ready.
  - When adv=1, every stage shifts one step. Bubbles (valid=0) shift too.
  - When adv=0, every stage register and every output holds stable.
  - A result is consumed when out_valid & out_ready.
- Latency and throughput:
  - Accept in cycle t gives out_valid in cycle t+STAGES, given no stall.
  - Throughput is one result per cycle while out_ready=1.
  - Ordering is strictly FIFO.
- Simultaneous events:
  - Consume and accept in the same cycle is legal; the pipeline stays full.
  - in_valid=0 with adv=1 inserts a bubble.
- Reset mid-operation: all in-flight beats are dropped. No partial result ever appears on the outputs.
- Input stability: x, y, c_in and sub are sampled only on acceptance. They need not be held afterwards.
- Output stability: sum and flags are don't-care when out_valid=0, but read 0 after reset until the first valid result.

Test Plan (WIDTH=16, STAGES=4 unless noted):
- Wrap add: x=0xFFFF, y=0x0001, c_in=0, sub=0, accepted at cycle t.
  - Required at cycle t+4: out_valid=1, sum=0x0000, c_out=1, zero=1, ovf=0.
- Signed overflow: x=0x7FFF, y=0x0001, c_in=0.
  - Required: sum=0x8000, ovf=1, c_out=0, zero=0.
- Subtract with borrow: x=0x0005, y=0x0007, sub=1, c_in=0.
  - Required: sum=0xFFFE, c_out=0, ovf=0.
  - Same operands with c_in=1: sum=0xFFFD.
- Streaming: 8 back-to-back random beats with out_ready=1.
  - Required: 8 consecutive out_valid cycles starting 4 cycles after the first accept, results in order, all matching a reference model.
- Backpressure: pipeline full, out_ready=0 for 3 cycles.
  - Required: in_ready=0 throughout, with sum and flags stable.
  - On release, one result per cycle with no loss or duplication.
- Reset mid-stream: rst pulsed with 3 beats in flight.
  - Required: out_valid=0 from the next cycle, no stale result afterwards, in_ready=1.
  - Repeat with WIDTH=32, STAGES=1: latency is 1 cycle and 0xFFFFFFFF+1 gives sum 0, c_out=1.
